// File: rtl/uart_num_digitizer_if.sv
// Digitizer handshake bundle: start/value request side and digit/valid/ready/last stream side.
// Carries no state. Backpressure is the digit_valid/digit_ready pair.
// master drives requests and consumes digits; slave is the digitizer.
interface uart_num_digitizer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             digit_ready;
    logic             last;

    modport master (
        output start, value, digit_ready,
        input  busy, digit, digit_valid, last
    );

    modport slave (
        input  start, value, digit_ready,
        output busy, digit, digit_valid, last
    );
endinterface

// File: rtl/uart_num_digitizer.sv
// Binary to decimal digits via double dabble, MSD first; UART_DIGITIZER_LZ_SUPPRESS_EN drops leading zeros.
// Latency: first digit valid WIDTH+2 cycles after the accepting start edge, then 1 digit/clk.
// Backpressure: digit/last held while digit_valid && !digit_ready; start ignored while busy.
module uart_num_digitizer #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    uart_num_digitizer_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = WIDTH + 4 * DIGITS + 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(DIGITS - 1);

    // 10^DIGITS must exceed the largest WIDTH-bit value or the top digit overflows.
    function automatic bit digits_fit();
        logic [PW-1:0] p;
        logic [PW-1:0] mx;
        p  = PW'(1);
        mx = '1;
        mx = mx >> (PW - WIDTH);
        for (int i = 0; i < DIGITS; i++) p = p * PW'(10);
        return p > mx;
    endfunction

    generate
        if (!digits_fit()) begin : g_digits_check
            $error("uart_num_digitizer: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONVERT, SCAN, EMIT} state_t;

    state_t          state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [BW-1:0]    bcd, bcd_n, bcd_adj;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n, lead_idx;
    logic [3:0]       sel_digit;
    logic             xfer;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef UART_DIGITIZER_LZ_SUPPRESS_EN
    // Ascending scan so the highest nonzero nibble wins; all-zero falls back to digit 0.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) lead_idx = IW'(i);
        end
    end
`else
    assign lead_idx = TOP_IDX;
`endif

    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) sel_digit = bcd[4*i +: 4];
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.digit_valid = (state == EMIT);
    assign bus.last        = (state == EMIT) && (idx == '0);
    assign bus.digit       = (state == EMIT) ? sel_digit : 4'd0;
    assign xfer            = bus.digit_valid && bus.digit_ready;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        bcd_n   = bcd;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    sh_n    = bus.value;
                    bcd_n   = '0;
                    cnt_n   = CW'(WIDTH);
                    idx_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_n, sh_n} = {bcd_adj, sh} << 1;
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) state_n = SCAN;
            end
            SCAN: begin
                idx_n   = lead_idx;
                state_n = EMIT;
            end
            EMIT: begin
                if (xfer) begin
                    if (idx == '0) state_n = IDLE;
                    else           idx_n   = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            bcd   <= bcd_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end
endmodule

// File: tb/tb_uart_num_digitizer.sv
// Bench for uart_num_digitizer: vector table of values/ready patterns, digit scoreboard, latency/hold/reset checks.
module tb_uart_num_digitizer;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int NVEC   = 10;

    logic clk = 1'b0;
    logic rst;

    uart_num_digitizer_if #(.WIDTH(WIDTH)) bus ();

    uart_num_digitizer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] digit;
        logic       last;
    } exp_t;

    // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready.
    typedef struct {
        int value;
        int mode;
        int glitch;
        bit rst_mid;
        int exp_first;
        int exp_n;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[NVEC];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference digits by repeated division, independent of the shift-add-3 datapath.
    task automatic push_expected(input int v);
        int d[DIGITS];
        int x;
        int first;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = x % 10;
            x = x / 10;
        end
        first = DIGITS - 1;
`ifdef UART_DIGITIZER_LZ_SUPPRESS_EN
        while (first > 0 && d[first] == 0) first--;
`endif
        for (int i = first; i >= 0; i--) sb.push_back('{digit: 4'(d[i]), last: (i == 0)});
    endtask

    task automatic run_one(input vec_t t);
        int         cyc, first_cyc, nxfer, first_dig, pat;
        bit         done, held;
        logic [3:0] hdig;
        logic       hlast;
        exp_t       e;

        bus.start = 1'b1;
        bus.value = WIDTH'(t.value);
        push_expected(t.value);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; first_cyc = -1; nxfer = 0; first_dig = -1; pat = 0; done = 0; held = 0;
        hdig = 4'd0; hlast = 1'b0;
        check("busy_after_start", bus.busy, 1);

        while (!done && cyc < 300) begin
            if (t.rst_mid && nxfer == 1) begin
                bus.digit_ready = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_busy", bus.busy, 0);
                check("rst_valid", bus.digit_valid, 0);
                sb.delete();
                done = 1;
            end else begin
                bus.start = (cyc == t.glitch);
                if (bus.start) bus.value = WIDTH'(5);
                case (t.mode)
                    0:       bus.digit_ready = 1'b1;
                    1:       bus.digit_ready = (pat % 3 == 0);
                    default: bus.digit_ready = 1'($urandom_range(0, 1));
                endcase
                if (held) begin
                    check("hold_valid", bus.digit_valid, 1);
                    check("hold_digit", bus.digit, hdig);
                    check("hold_last", bus.last, hlast);
                end
                held = 0;
                if (bus.digit_valid) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    pat++;
                    if (bus.digit_ready) begin
                        nxfer++;
                        if (first_dig < 0) first_dig = int'(bus.digit);
                        if (sb.size() == 0) begin
                            check("extra_digit", nxfer, 0);
                        end else begin
                            e = sb.pop_front();
                            check("digit", bus.digit, e.digit);
                            check("last", bus.last, e.last);
                        end
                        if (bus.last) done = 1;
                    end else begin
                        held  = 1;
                        hdig  = bus.digit;
                        hlast = bus.last;
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start = 1'b0;

        check("completed", done, 1);
        check("latency", first_cyc, WIDTH + 2);
        check("n_digits", nxfer, t.exp_n);
        check("first_digit", first_dig, t.exp_first);
        if (!t.rst_mid) begin
            check("busy_drop", bus.busy, 0);
            check("valid_drop", bus.digit_valid, 0);
            check("last_drop", bus.last, 0);
            check("sb_empty", sb.size(), 0);
        end
    endtask

    initial begin
`ifdef UART_DIGITIZER_LZ_SUPPRESS_EN
        vecs[0] = '{value: 12345, mode: 0, glitch: 0, rst_mid: 0, exp_first: 1, exp_n: 5};
        vecs[1] = '{value: 0,     mode: 0, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 1};
        vecs[2] = '{value: 65535, mode: 0, glitch: 0, rst_mid: 0, exp_first: 6, exp_n: 5};
        vecs[3] = '{value: 907,   mode: 1, glitch: 0, rst_mid: 0, exp_first: 9, exp_n: 3};
        vecs[4] = '{value: 321,   mode: 0, glitch: 5, rst_mid: 0, exp_first: 3, exp_n: 3};
        vecs[5] = '{value: 4567,  mode: 0, glitch: 0, rst_mid: 1, exp_first: 4, exp_n: 1};
        vecs[6] = '{value: 89,    mode: 0, glitch: 0, rst_mid: 0, exp_first: 8, exp_n: 2};
        vecs[7] = '{value: 42,    mode: 2, glitch: 0, rst_mid: 0, exp_first: 4, exp_n: 2};
        vecs[8] = '{value: 10000, mode: 1, glitch: 0, rst_mid: 0, exp_first: 1, exp_n: 5};
        vecs[9] = '{value: 9,     mode: 1, glitch: 0, rst_mid: 0, exp_first: 9, exp_n: 1};
`else
        vecs[0] = '{value: 12345, mode: 0, glitch: 0, rst_mid: 0, exp_first: 1, exp_n: 5};
        vecs[1] = '{value: 0,     mode: 0, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 5};
        vecs[2] = '{value: 65535, mode: 0, glitch: 0, rst_mid: 0, exp_first: 6, exp_n: 5};
        vecs[3] = '{value: 907,   mode: 1, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 5};
        vecs[4] = '{value: 321,   mode: 0, glitch: 5, rst_mid: 0, exp_first: 0, exp_n: 5};
        vecs[5] = '{value: 4567,  mode: 0, glitch: 0, rst_mid: 1, exp_first: 0, exp_n: 1};
        vecs[6] = '{value: 89,    mode: 0, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 5};
        vecs[7] = '{value: 42,    mode: 2, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 5};
        vecs[8] = '{value: 10000, mode: 1, glitch: 0, rst_mid: 0, exp_first: 1, exp_n: 5};
        vecs[9] = '{value: 9,     mode: 1, glitch: 0, rst_mid: 0, exp_first: 0, exp_n: 5};
`endif

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.value       = '0;
        bus.digit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.digit_valid, 0);
        check("reset_digit", bus.digit, 0);
        check("reset_last", bus.last, 0);

        // Ready asserted with nothing valid must not disturb the idle block.
        rst = 1'b0;
        bus.digit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_valid", bus.digit_valid, 0);
        check("idle_ready_busy", bus.busy, 0);

        // Vectors run back to back: each start lands in the IDLE cycle after the previous last.
        for (int i = 0; i < NVEC; i++) run_one(vecs[i]);

        bus.digit_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("final_idle_valid", bus.digit_valid, 0);
        check("final_idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_num_digitizer.md
Name: uart_num_digitizer

Overview:
- Converts a latched unsigned binary value into decimal digits (0-9) and emits them one per handshake, most significant digit first.
- Sits directly upstream of uart_num2ascii: the digit output, zero-extended to 8 bits, drives its num input, and the resulting ASCII byte goes to the UART tx buffer.
- Binary-to-BCD conversion is shift-and-add-3 (double dabble), one bit per clock.

Parameters:
- WIDTH, 16, bit width of the input value.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH-1; violating this is an elaboration error.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of value; sampled only in IDLE.
- value  input  WIDTH  unsigned binary number; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until the final digit transfers.
- digit  output  4  current BCD digit, 0-9; zero-extend to 8 bits for uart_num2ascii.
- digit_valid  output  1  digit is valid; held until accepted.
- digit_ready  input  1  downstream accepts the digit; a transfer happens when digit_valid and digit_ready are both high on a clk edge.
- last  output  1  qualifies digit_valid; high for the final digit of the number.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On reset: state=IDLE, busy=0, digit=0, digit_valid=0, last=0, internal shift/BCD registers cleared.
- rst asserted in any state, including mid-CONVERT or mid-EMIT, returns the block to IDLE on that edge. A pending digit is dropped and no further digits are emitted.
- IDLE:
  - start=1 at edge N latches value, clears the BCD register, loads bit counter = WIDTH, and moves to CONVERT.
  - busy=1 from cycle N+1.
- CONVERT, WIDTH cycles:
  - Each cycle, every BCD nibble >=5 gets +3.
  - Then {bcd, shift} shifts left by 1 and the counter decrements.
  - When the counter reaches 0, move to SCAN.
- SCAN, 1 cycle:
  - Locate the most significant nonzero digit with a priority encoder; set the digit index to it.
  - If all digits are zero, set the index to the least significant digit.
  - Move to EMIT.
- EMIT:
  - digit_valid=1 and digit=bcd[index] from cycle N+WIDTH+2.
  - last=1 when index = least significant digit.
  - On a transfer with last=0: the index steps down one digit and the next digit is presented the following cycle, so digit_valid stays high (back-to-back transfers at 1 digit/clk when ready is high).
  - On a transfer with last=1: next cycle state=IDLE and busy, digit_valid, last = 0. start may be accepted in that IDLE cycle.
- Backpressure: while digit_valid=1 and digit_ready=0, digit and last hold stable.
- start while busy is ignored; value is not re-latched.
- digit_ready while digit_valid=0 has no effect.
- Maximum input 2^WIDTH-1 (65535 at defaults) converts exactly; no saturation logic is required.

Optional Feature:
- Macro: UART_DIGITIZER_LZ_SUPPRESS_EN.
- Defined: SCAN skips leading zeros as described; value 0 emits the single digit 0.
- Undefined: SCAN always sets the index to the most significant digit, so exactly DIGITS digits are emitted including leading zeros (e.g. 42 -> 0,0,0,4,2). Latency is unchanged.

Test Plan:
- Feature on, digit_ready held 1, start with value=12345 -> digits 1,2,3,4,5 on consecutive cycles from cycle N+18; last only with 5; busy falls the cycle after.
- Feature on, value=0 -> exactly one digit 0 with last=1; value=65535 -> 6,5,5,3,5.
- Backpressure: value=907, digit_ready toggled 1,0,0,1,... -> digits 9,0,7 each held stable while ready=0; no drops or duplicates.
- start pulsed with value=5 while busy converting 321 -> only 3,2,1 emitted; the second start is ignored.
- rst asserted after the first digit of 4567 transfers -> next cycle busy=0, digit_valid=0; a fresh start with 89 then yields 8,9.
- Feature off, value=42 -> 0,0,0,4,2 with last on 2.
